// File: rtl/vga_timing_gen_if.sv
`timescale 1ns/1ps
// VGA raster bus. master: timing generator (drives DAC pins and pixel
// requests, receives pixel data). slave: pixel source / DAC side.
interface vga_timing_gen_if #(
  parameter int DATA_W = 24,
  parameter int CW     = 12
);
  logic              vga_dclk;
  logic              vga_hs;
  logic              vga_vs;
  logic              vga_blank;
  logic              vga_sync;
  logic              vga_en;
  logic [DATA_W-1:0] vga_rgb;
  logic              vga_request;
  logic [CW-1:0]     vga_xpos;
  logic [CW-1:0]     vga_ypos;
  logic [DATA_W-1:0] vga_data;

  modport master (
    output vga_dclk, vga_hs, vga_vs, vga_blank, vga_sync, vga_en, vga_rgb,
           vga_request, vga_xpos, vga_ypos,
    input  vga_data
  );

  modport slave (
    input  vga_dclk, vga_hs, vga_vs, vga_blank, vga_sync, vga_en, vga_rgb,
           vga_request, vga_xpos, vga_ypos,
    output vga_data
  );
endinterface

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// Parametrised VGA raster timing generator with frame-aligned run/stop.
// Ports: clk_25m pixel clock, rst async active-high reset, run scan enable,
// vga (bus master), sof start-of-frame pulse, frame_cnt completed frames,
// busy scanning (RUN or STOP).
module vga_timing_gen #(
  parameter int   H_DISP  = 640,
  parameter int   H_FRONT = 16,
  parameter int   H_SYNC  = 96,
  parameter int   H_BACK  = 48,
  parameter int   V_DISP  = 480,
  parameter int   V_FRONT = 10,
  parameter int   V_SYNC  = 2,
  parameter int   V_BACK  = 33,
  parameter logic HS_POL  = 1'b0,
  parameter logic VS_POL  = 1'b0,
  parameter int   LEAD    = 1,
  parameter int   DATA_W  = 24,
  parameter int   CW      = 12
) (
  input  logic               clk_25m,
  input  logic               rst,
  input  logic               run,
  vga_timing_gen_if.master   vga,
  output logic               sof,
  output logic [15:0]        frame_cnt,
  output logic               busy
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int HA      = H_SYNC + H_BACK;
  localparam int VA      = V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SY_END = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SY_END = CW'(V_SYNC);
  localparam logic [CW-1:0] H_EN_LO  = CW'(HA);
  localparam logic [CW-1:0] H_EN_HI  = CW'(HA + H_DISP);
  localparam logic [CW-1:0] H_RQ_LO  = CW'(HA - LEAD);
  localparam logic [CW-1:0] H_RQ_HI  = CW'(HA + H_DISP - LEAD);
  localparam logic [CW-1:0] V_EN_LO  = CW'(VA);
  localparam logic [CW-1:0] V_EN_HI  = CW'(VA + V_DISP);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] hcnt, vcnt;
  logic          active, h_last, frame_last;
  logic          h_en, h_rq, v_en, en, rq;

  assign active     = (state != IDLE);
  assign h_last     = (hcnt == H_LAST);
  assign frame_last = h_last && (vcnt == V_LAST);

  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Leaving STOP only happens on the last frame cycle, so IDLE is always
  // entered with the counters already wrapped to zero.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = RUN;
      RUN:     if (!run) state_nxt = STOP;
      STOP:    if (run) state_nxt = RUN;
               else if (frame_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      hcnt      <= '0;
      vcnt      <= '0;
      frame_cnt <= '0;
    end else if (!active) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CW'(1);
      if (vcnt == V_LAST) frame_cnt <= frame_cnt + 16'd1;
    end else begin
      hcnt <= hcnt + CW'(1);
    end
  end

  assign h_en = (hcnt >= H_EN_LO) && (hcnt < H_EN_HI);
  assign h_rq = (hcnt >= H_RQ_LO) && (hcnt < H_RQ_HI);
  assign v_en = (vcnt >= V_EN_LO) && (vcnt < V_EN_HI);
  assign en   = active && h_en && v_en;
  assign rq   = active && h_rq && v_en;

  assign vga.vga_dclk    = ~clk_25m;
  assign vga.vga_hs      = (active && (hcnt < H_SY_END)) ? HS_POL : ~HS_POL;
  assign vga.vga_vs      = (active && (vcnt < V_SY_END)) ? VS_POL : ~VS_POL;
  assign vga.vga_en      = en;
  assign vga.vga_blank   = en;
  assign vga.vga_sync    = 1'b0;
  assign vga.vga_rgb     = en ? vga.vga_data : '0;
  assign vga.vga_request = rq;
  assign vga.vga_xpos    = rq ? (hcnt - H_RQ_LO) : '0;
  assign vga.vga_ypos    = rq ? (vcnt - V_EN_LO) : '0;

  assign sof  = active && (hcnt == '0) && (vcnt == '0);
  assign busy = active;

endmodule
